alu_seq_ctrl: RTL and testbench

- Micro-sequencer that drives the 8-entry ALU/register-file datapath.
- Holds a small program memory loaded by a host. On start, it issues one instruction per slot (op, rd, rs1, rs2, imm) onto the datapath's control inputs.
- After the last issue, it waits out the datapath result latency and returns the final result with a done pulse.
- Sits between the host/control bus and the datapath; it is the only driver of the datapath control inputs.

---
 rtl/alu_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - micro-sequencer issuing a stored program onto the ALU/register-file datapath
// Outputs are registered; dp_* fall back to the all-zero idle encoding whenever issue is low.
module alu_seq_ctrl #(
    parameter int DEPTH      = 16,
    parameter int GAP        = 0,
    parameter int RESULT_LAT = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [43:0]   prog_wdata,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [31:0]   result_out,
    output logic [AW-1:0] pc,
    output logic          issue,
    output logic [2:0]    dp_op,
    output logic [2:0]    dp_rd,
    output logic [2:0]    dp_rs1,
    output logic [2:0]    dp_rs2,
    output logic [31:0]   dp_imm,
    input  logic [31:0]   dp_result
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAPW, S_DRAIN} state_t;

    state_t        r_state;
    logic [43:0]   r_mem [DEPTH];
    logic [AW:0]   r_len;
    logic [2:0]    r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_issue;
    logic [AW-1:0] r_pc;
    logic [31:0]   r_result;
    logic [43:0]   r_dp;

    logic [AW-1:0] w_next_pc;
    logic          w_last;
    logic [AW:0]   w_len_clamped;

    assign w_next_pc     = r_pc + AW'(1);
    assign w_last        = ({1'b0, r_pc} + (AW+1)'(1)) >= r_len;
    assign w_len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;

    assign busy       = r_busy;
    assign done       = r_done;
    assign issue      = r_issue;
    assign pc         = r_pc;
    assign result_out = r_result;
    assign {dp_op, dp_rd, dp_rs1, dp_rs2, dp_imm} = r_dp;

    // Program memory survives rst so the host need not reload after a reset.
    always_ff @(posedge clk) begin
        if (prog_we && r_state == S_IDLE) begin
            r_mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_len    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_issue  <= 1'b0;
            r_pc     <= '0;
            r_result <= '0;
            r_dp     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (prog_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_len   <= w_len_clamped;
                            r_dp    <= r_mem[0];
                            r_issue <= 1'b1;
                            r_pc    <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_issue <= 1'b0;
                        r_dp    <= '0;
                    end else if (!w_last) begin
                        if (GAP == 0) begin
                            r_dp <= r_mem[w_next_pc];
                            r_pc <= w_next_pc;
                        end else begin
                            r_state <= S_GAPW;
                            r_cnt   <= 3'(GAP - 1);
                            r_issue <= 1'b0;
                            r_dp    <= '0;
                        end
                    end else begin
                        r_state <= S_DRAIN;
                        r_cnt   <= 3'(RESULT_LAT - 1);
                        r_issue <= 1'b0;
                        r_dp    <= '0;
                    end
                end
                S_GAPW: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_dp    <= r_mem[w_next_pc];
                        r_pc    <= w_next_pc;
                        r_issue <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DRAIN: begin
                    // abort wins over the completion edge: no done, result kept.
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == '0) begin
                        r_result <= dp_result;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - bench for alu_seq_ctrl, two instances (GAP=0/LAT=1 and GAP=2/LAT=3)
// Expected cycle traces are built from the issue/gap/drain rules and compared every cycle.
module tb_alu_seq_ctrl;

    localparam int GAP_B = 2;
    localparam int LAT_B = 3;

    typedef struct packed {
        logic        issue;
        logic        busy;
        logic        done;
        logic [3:0]  pc;
        logic [43:0] word;
        logic [31:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [43:0] prog_wdata = '0;
    logic        start = 1'b0;
    logic [4:0]  prog_len = '0;
    logic        abort = 1'b0;
    logic [31:0] dp_result;
    int          cyc = 0;

    logic        a_busy, a_done, a_issue, b_busy, b_done, b_issue;
    logic [31:0] a_res, b_res, a_imm, b_imm;
    logic [3:0]  a_pc, b_pc;
    logic [2:0]  a_op, a_rd, a_rs1, a_rs2, b_op, b_rd, b_rs1, b_rs2;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [43:0] mem_m [16];
    logic [31:0] prev_a = '0;
    logic [31:0] prev_b = '0;
    exp_t        qa[$];
    exp_t        qb[$];

    function automatic logic [31:0] f_res(input int x);
        return 32'h5A00_0000 ^ (x * 32'h0000_9E37);
    endfunction

    assign dp_result = f_res(cyc);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_seq_ctrl #(.DEPTH(16), .GAP(0), .RESULT_LAT(1)) u_a (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .start(start), .prog_len(prog_len), .abort(abort), .busy(a_busy), .done(a_done),
        .result_out(a_res), .pc(a_pc), .issue(a_issue), .dp_op(a_op), .dp_rd(a_rd),
        .dp_rs1(a_rs1), .dp_rs2(a_rs2), .dp_imm(a_imm), .dp_result(dp_result)
    );

    alu_seq_ctrl #(.DEPTH(16), .GAP(GAP_B), .RESULT_LAT(LAT_B)) u_b (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .start(start), .prog_len(prog_len), .abort(abort), .busy(b_busy), .done(b_done),
        .result_out(b_res), .pc(b_pc), .issue(b_issue), .dp_op(b_op), .dp_rd(b_rd),
        .dp_rs1(b_rs1), .dp_rs2(b_rs2), .dp_imm(b_imm), .dp_result(dp_result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_dut(input int which, input exp_t e);
        string p;
        logic b, d, i;
        logic [3:0] pcv;
        logic [43:0] w;
        logic [31:0] r;
        if (which == 0) begin
            p = "a"; b = a_busy; d = a_done; i = a_issue; pcv = a_pc; r = a_res;
            w = {a_op, a_rd, a_rs1, a_rs2, a_imm};
        end else begin
            p = "b"; b = b_busy; d = b_done; i = b_issue; pcv = b_pc; r = b_res;
            w = {b_op, b_rd, b_rs1, b_rs2, b_imm};
        end
        chk({p, ".issue"}, 64'(i), 64'(e.issue));
        chk({p, ".busy"}, 64'(b), 64'(e.busy));
        chk({p, ".done"}, 64'(d), 64'(e.done));
        chk({p, ".dp_word"}, 64'(w), 64'(e.word));
        chk({p, ".result_out"}, 64'(r), 64'(e.res));
        if (e.issue) chk({p, ".pc"}, 64'(pcv), 64'(e.pc));
    endtask

    task automatic check_idle(input int which);
        exp_t e;
        e = '0;
        e.res = (which == 0) ? prev_a : prev_b;
        check_dut(which, e);
    endtask

    // Expected per-cycle trace after the start edge: N issues with gap bubbles, drain, done.
    task automatic build(input int which, input int len, input int ks, input int intr_at, input bit use_rst);
        exp_t q[$];
        exp_t e;
        int n, gap, lat, t;
        logic [31:0] prev;
        gap  = (which == 0) ? 0 : GAP_B;
        lat  = (which == 0) ? 1 : LAT_B;
        prev = (which == 0) ? prev_a : prev_b;
        n    = (len > 16) ? 16 : len;
        if (n == 0) begin
            e = '0; e.done = 1'b1; e.res = prev; q.push_back(e);
        end else begin
            for (int i = 0; i < n; i++) begin
                e = '0; e.issue = 1'b1; e.busy = 1'b1; e.pc = 4'(i); e.word = mem_m[i]; e.res = prev;
                q.push_back(e);
                if (i < n - 1) begin
                    for (int g = 0; g < gap; g++) begin
                        e = '0; e.busy = 1'b1; e.res = prev; q.push_back(e);
                    end
                end
            end
            for (int l = 0; l < lat; l++) begin
                e = '0; e.busy = 1'b1; e.res = prev; q.push_back(e);
            end
            t = n + (n - 1) * gap + lat;
            e = '0; e.done = 1'b1; e.res = f_res(ks + t); q.push_back(e);
        end
        if (intr_at >= 0 && intr_at + 1 < q.size()) begin
            while (q.size() > intr_at + 1) void'(q.pop_back());
            e = '0; e.res = use_rst ? 32'h0 : prev; q.push_back(e);
        end
        if (which == 0) begin qa = q; prev_a = q[$].res; end
        else begin qb = q; prev_b = q[$].res; end
    endtask

    task automatic wr(input int addr, input logic [43:0] data);
        prog_we = 1'b1; prog_addr = 4'(addr); prog_wdata = data;
        @(negedge clk);
        prog_we = 1'b0;
        mem_m[addr] = data;
    endtask

    task automatic run(input int len, input int intr_at, input bit use_rst, input bit poke);
        int j;
        start = 1'b1; prog_len = 5'(len);
        build(0, len, cyc, intr_at, use_rst);
        build(1, len, cyc, intr_at, use_rst);
        @(negedge clk);
        start = 1'b0; prog_len = '0;
        j = 0;
        while (qa.size() > 0 || qb.size() > 0) begin
            if (qa.size() > 0) check_dut(0, qa.pop_front()); else check_idle(0);
            if (qb.size() > 0) check_dut(1, qb.pop_front()); else check_idle(1);
            abort      = (j == intr_at) && !use_rst;
            rst        = (j == intr_at) && use_rst;
            prog_we    = poke && (j == 1);
            start      = poke && (j == 1);
            prog_len   = 5'd1;
            prog_addr  = '0;
            prog_wdata = 44'({$urandom(), $urandom()});
            @(negedge clk);
            j++;
        end
        abort = 1'b0; rst = 1'b0; prog_we = 1'b0; start = 1'b0; prog_len = '0;
        repeat (2) begin
            check_idle(0); check_idle(1);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t z;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        z = '0;
        check_dut(0, z);
        check_dut(1, z);
        chk("a.pc_rst", 64'(a_pc), 64'h0);
        chk("b.pc_rst", 64'(b_pc), 64'h0);

        wr(0, {3'd7, 3'd1, 3'd0, 3'd0, 32'd5});
        wr(1, {3'd7, 3'd2, 3'd0, 3'd0, 32'd7});
        wr(2, {3'd0, 3'd3, 3'd1, 3'd2, 32'd0});
        for (int i = 3; i < 16; i++) wr(i, 44'({$urandom(), $urandom()}));

        run(3, -1, 1'b0, 1'b0);
        run(2, -1, 1'b0, 1'b0);
        run(0, -1, 1'b0, 1'b0);
        run(19, -1, 1'b0, 1'b0);
        run(5, 1, 1'b0, 1'b0);
        run(4, -1, 1'b0, 1'b0);
        run(6, -1, 1'b0, 1'b1);
        run(3, -1, 1'b0, 1'b0);
        run(1, 1, 1'b1, 1'b0);
        run(3, -1, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            wr(int'($urandom_range(0, 15)), 44'({$urandom(), $urandom()}));
            wr(int'($urandom_range(0, 15)), 44'({$urandom(), $urandom()}));
            run(int'($urandom_range(1, 16)), -1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
